// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 data-memory access path.
// Holds the access-controller state encoding, the load/store size encodings,
// the timeout counter width, and the alignment rule used when a request is
// accepted.
package msrv32_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;  // 2'b11 is also treated as word

  localparam int CNT_W = 16;

  // Halves need addr[0]=0, words need addr[1:0]=00; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      LS_BYTE: return 1'b0;
      LS_HALF: return addr_lo[0];
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/msrv32_store_lane_gen.sv
// Combinational store-lane generator.
// Produces the byte-enable mask and lane-replicated write data for a store of
// the given size at the given byte offset within the word.
// Ports:
//   size    - access size (LS_BYTE / LS_HALF / LS_WORD)
//   addr_lo - byte offset addr[1:0]
//   rs2     - raw store data
//   wmask   - byte enables
//   wdata   - store data replicated onto every lane the size can occupy
module msrv32_store_lane_gen
  import msrv32_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  output logic [3:0]  wmask,
  output logic [31:0] wdata
);

  always_comb begin
    wmask = 4'b1111;
    wdata = rs2;
    case (size)
      LS_BYTE: begin
        wmask = 4'b0001 << addr_lo;
        wdata = {4{rs2[7:0]}};
      end
      LS_HALF: begin
        wmask = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rs2[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wdata = rs2;
      end
    endcase
  end

endmodule

// File: rtl/msrv32_dmem_access_ctrl.sv
// Data-memory access controller for the msrv32 core.
// Accepts one load/store per request, checks alignment, drives the data bus
// until ready or timeout, and hands registered results to the load unit while
// stalling the pipeline for the whole access.
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in - clock, sync active-high reset
//   mem_req_in, mem_wr_in, iadder_in, rs2_in, load_size_in - request from execute
//   dm_req_out, dm_wr_out, dm_addr_out, dm_wdata_out, dm_wmask_out - bus request
//   dm_ready_in, dm_rdata_in, dm_err_in - bus response
//   stall_out, done_out - pipeline control
//   ms_riscv32_mp_dmdata_out, ahb_resp_out, iadder_out_1_to_0_out,
//   misaligned_out - held results for the load unit
module msrv32_dmem_access_ctrl
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        mem_req_in,
  input  logic        mem_wr_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic [1:0]  load_size_in,
  output logic        dm_req_out,
  output logic        dm_wr_out,
  output logic [31:0] dm_addr_out,
  output logic [31:0] dm_wdata_out,
  output logic [3:0]  dm_wmask_out,
  input  logic        dm_ready_in,
  input  logic [31:0] dm_rdata_in,
  input  logic        dm_err_in,
  output logic        stall_out,
  output logic        done_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        ahb_resp_out,
  output logic [1:0]  iadder_out_1_to_0_out,
  output logic        misaligned_out
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  state_t           state_next;
  logic             wr_q;
  logic [31:0]      addr_q;
  logic [31:0]      rs2_q;
  logic [1:0]       size_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata_q;
  logic             resp_q;
  logic             misal_q;
  logic             req_misaligned;
  logic             timeout;
  logic [3:0]       lane_mask;
  logic [31:0]      lane_wdata;

  assign req_misaligned = is_misaligned(load_size_in, iadder_in[1:0]);
  assign timeout        = (cnt >= TO_LIMIT);

  msrv32_store_lane_gen u_lane_gen (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .rs2     (rs2_q),
    .wmask   (lane_mask),
    .wdata   (lane_wdata)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) state <= S_IDLE;
    else                      state <= state_next;
  end

  // Stall is combinational in IDLE so the requesting instruction freezes in
  // the same cycle; it drops in DONE so the pipeline advances with the result.
  always_comb begin
    state_next = state;
    stall_out  = 1'b0;
    done_out   = 1'b0;
    dm_req_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_req_in) begin
          stall_out  = 1'b1;
          state_next = req_misaligned ? S_DONE : S_BUS;
        end
      end
      S_BUS: begin
        stall_out  = 1'b1;
        dm_req_out = 1'b1;
        if (dm_ready_in || timeout) state_next = S_DONE;
      end
      S_DONE: begin
        done_out   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      rs2_q   <= '0;
      size_q  <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      misal_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_req_in) begin
            wr_q    <= mem_wr_in;
            addr_q  <= iadder_in;
            rs2_q   <= rs2_in;
            size_q  <= load_size_in;
            cnt     <= '0;
            misal_q <= req_misaligned;
            resp_q  <= req_misaligned;
          end
        end
        S_BUS: begin
          // Ready takes priority over a timeout in the same cycle.
          if (dm_ready_in) begin
            resp_q <= dm_err_in;
            if (!wr_q) rdata_q <= dm_rdata_in;
          end else if (timeout) begin
            resp_q <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dm_wr_out                = wr_q & (state == S_BUS);
  assign dm_addr_out              = {addr_q[31:2], 2'b00};
  assign dm_wdata_out             = lane_wdata;
  assign dm_wmask_out             = wr_q ? lane_mask : 4'b0000;
  assign ms_riscv32_mp_dmdata_out = rdata_q;
  assign ahb_resp_out             = resp_q;
  assign iadder_out_1_to_0_out    = addr_q[1:0];
  assign misaligned_out           = misal_q;

endmodule

// File: tb/tb_msrv32_dmem_access_ctrl.sv
module tb_msrv32_dmem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_in, mem_wr_in;
  logic [31:0] iadder_in, rs2_in;
  logic [1:0]  load_size_in;
  logic        dm_req_out, dm_wr_out;
  logic [31:0] dm_addr_out, dm_wdata_out;
  logic [3:0]  dm_wmask_out;
  logic        dm_ready_in;
  logic [31:0] dm_rdata_in;
  logic        dm_err_in;
  logic        stall_out, done_out;
  logic [31:0] dmdata;
  logic        ahb_resp_out;
  logic [1:0]  addr_lo_out;
  logic        misaligned_out;

  int nvec = 0;
  int nerr = 0;

  // Reference model of the held load-unit results.
  logic [31:0] m_data;
  logic        m_resp, m_misal;
  logic [1:0]  m_lo;

  msrv32_dmem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .ms_riscv32_mp_clk_in     (clk),
    .ms_riscv32_mp_rst_in     (rst),
    .mem_req_in               (mem_req_in),
    .mem_wr_in                (mem_wr_in),
    .iadder_in                (iadder_in),
    .rs2_in                   (rs2_in),
    .load_size_in             (load_size_in),
    .dm_req_out               (dm_req_out),
    .dm_wr_out                (dm_wr_out),
    .dm_addr_out              (dm_addr_out),
    .dm_wdata_out             (dm_wdata_out),
    .dm_wmask_out             (dm_wmask_out),
    .dm_ready_in              (dm_ready_in),
    .dm_rdata_in              (dm_rdata_in),
    .dm_err_in                (dm_err_in),
    .stall_out                (stall_out),
    .done_out                 (done_out),
    .ms_riscv32_mp_dmdata_out (dmdata),
    .ahb_resp_out             (ahb_resp_out),
    .iadder_out_1_to_0_out    (addr_lo_out),
    .misaligned_out           (misaligned_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int nbytes_of(input logic [1:0] s);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 2;
    return 4;
  endfunction

  // Bytes covered by an access of n bytes at offset lo.
  function automatic logic [3:0] ref_mask(input logic [1:0] s, input logic [1:0] lo);
    int n, base;
    logic [3:0] m;
    n = nbytes_of(s);
    base = (int'(lo) / n) * n;
    m = 4'b0000;
    for (int b = 0; b < 4; b++) if (b >= base && b < base + n) m[b] = 1'b1;
    return m;
  endfunction

  // Lane b carries store byte (b mod n).
  function automatic logic [31:0] ref_wdata(input logic [1:0] s, input logic [31:0] d);
    int n;
    logic [31:0] w;
    n = nbytes_of(s);
    w = '0;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = d[8*(b % n) +: 8];
    return w;
  endfunction

  task automatic idle_inputs();
    mem_req_in   = 1'b0;
    mem_wr_in    = 1'b0;
    iadder_in    = $urandom;
    rs2_in       = $urandom;
    load_size_in = 2'($urandom_range(0, 3));
    dm_ready_in  = 1'b0;
    dm_err_in    = 1'b0;
    dm_rdata_in  = $urandom;
  endtask

  // One complete access; ends in the DONE cycle (the next call's first cycle
  // is the IDLE cycle immediately after, giving back-to-back requests).
  task automatic run_access(input logic wr, input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [1:0] size, input int waits, input logic err,
                            input logic [31:0] rdata, input string tag);
    int          n, iend;
    logic        mis;
    logic [3:0]  wmask_exp;
    logic [35:0] got36, exp36;
    n   = nbytes_of(size);
    mis = (int'(addr[1:0]) % n) != 0;
    wmask_exp = wr ? ref_mask(size, addr[1:0]) : 4'b0000;

    @(negedge clk);
    mem_req_in = 1'b1; mem_wr_in = wr; iadder_in = addr; rs2_in = rs2; load_size_in = size;
    dm_ready_in = 1'b0;
    #1;
    nvec++;
    if ({dm_req_out, stall_out, done_out} !== 3'b010) begin
      nerr++;
      $display("FAIL %s accept_ctl: req/stall/done got %b want 010", tag, {dm_req_out, stall_out, done_out});
    end
    nvec++;
    if ({dmdata, ahb_resp_out, misaligned_out, addr_lo_out} !== {m_data, m_resp, m_misal, m_lo}) begin
      nerr++;
      $display("FAIL %s prior_hold: got %h/%b/%b/%b want %h/%b/%b/%b", tag, dmdata, ahb_resp_out,
               misaligned_out, addr_lo_out, m_data, m_resp, m_misal, m_lo);
    end

    @(negedge clk);
    idle_inputs();
    mem_wr_in = $urandom_range(0, 1);
    m_lo = addr[1:0];
    if (mis) begin
      m_resp  = 1'b1;
      m_misal = 1'b1;
    end else begin
      m_misal = 1'b0;
      iend = (waits < TO) ? waits : TO;
      for (int i = 0; i <= iend; i++) begin
        if (i > 0) @(negedge clk);
        dm_ready_in = (i == waits);
        dm_err_in   = (i == waits) ? err : 1'($urandom_range(0, 1));
        dm_rdata_in = (i == waits) ? rdata : $urandom;
        #1;
        nvec++;
        if ({dm_req_out, dm_wr_out, stall_out, done_out} !== {1'b1, wr, 1'b1, 1'b0}) begin
          nerr++;
          $display("FAIL %s bus_ctl[%0d]: req/wr/stall/done got %b want %b", tag, i,
                   {dm_req_out, dm_wr_out, stall_out, done_out}, {1'b1, wr, 2'b10});
        end
        got36 = {dm_addr_out, dm_wmask_out};
        exp36 = {addr[31:2], 2'b00, wmask_exp};
        nvec++;
        if (got36 !== exp36) begin
          nerr++;
          $display("FAIL %s bus_addr_mask[%0d]: got %h want %h", tag, i, got36, exp36);
        end
        if (wr) begin
          nvec++;
          if (dm_wdata_out !== ref_wdata(size, rs2)) begin
            nerr++;
            $display("FAIL %s bus_wdata[%0d]: got %h want %h", tag, i, dm_wdata_out, ref_wdata(size, rs2));
          end
        end
      end
      if (waits <= TO) begin
        m_resp = err;
        if (!wr) m_data = rdata;
      end else begin
        m_resp = 1'b1;
      end
      @(negedge clk);
      dm_ready_in = 1'b0;
      dm_err_in   = 1'b0;
    end

    // DONE cycle: a request here must be ignored.
    mem_req_in = 1'($urandom_range(0, 1));
    #1;
    nvec++;
    if ({dm_req_out, stall_out, done_out} !== 3'b001) begin
      nerr++;
      $display("FAIL %s done_ctl: req/stall/done got %b want 001", tag, {dm_req_out, stall_out, done_out});
    end
    nvec++;
    if ({dmdata, ahb_resp_out, misaligned_out, addr_lo_out} !== {m_data, m_resp, m_misal, m_lo}) begin
      nerr++;
      $display("FAIL %s done_result: got %h/%b/%b/%b want %h/%b/%b/%b", tag, dmdata, ahb_resp_out,
               misaligned_out, addr_lo_out, m_data, m_resp, m_misal, m_lo);
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [103:0] got;
    got = {dm_req_out, dm_wr_out, dm_addr_out, dm_wdata_out, dm_wmask_out, stall_out, done_out,
           dmdata[31:0], ahb_resp_out, addr_lo_out, misaligned_out};
    nvec++;
    if (got !== '0) begin
      nerr++;
      $display("FAIL %s all_zero: got %h want 0", tag, got);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    m_data = '0; m_resp = 1'b0; m_misal = 1'b0; m_lo = 2'b00;
  endtask

  task automatic test_store_byte();
    run_access(1'b1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 0, 1'b0, 32'h0, "store_byte");
  endtask

  task automatic test_load_wait3();
    run_access(1'b0, 32'h0000_4000, 32'h0, 2'b10, 3, 1'b0, 32'h1234_5678, "load_wait3");
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 32'h0000_2001, 32'h0, 2'b01, 0, 1'b0, 32'h0, "misalign_half");
    run_access(1'b1, 32'h0000_2002, 32'hCAFE_F00D, 2'b10, 0, 1'b0, 32'h0, "misalign_word");
  endtask

  task automatic test_timeout();
    run_access(1'b0, 32'h0000_5008, 32'h0, 2'b10, 1000, 1'b0, 32'h0, "timeout");
    run_access(1'b0, 32'h0000_500C, 32'h0, 2'b10, TO, 1'b0, 32'h9ABC_DEF0, "ready_at_limit");
  endtask

  task automatic test_bus_error();
    run_access(1'b0, 32'h0000_0002, 32'h0, 2'b00, 0, 1'b1, 32'h5555_AAAA, "bus_error");
  endtask

  task automatic test_reset_in_bus();
    @(negedge clk);
    idle_inputs();
    mem_req_in = 1'b1; mem_wr_in = 1'b0; iadder_in = 32'h0000_3006; load_size_in = 2'b01;
    @(negedge clk);
    idle_inputs();
    #1;
    nvec++;
    if (dm_req_out !== 1'b1) begin
      nerr++;
      $display("FAIL rst_bus pre: dm_req got %b want 1", dm_req_out);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("rst_bus");
    @(negedge clk);
    #1;
    nvec++;
    if ({dm_req_out, done_out} !== 2'b00) begin
      nerr++;
      $display("FAIL rst_bus no_done: req/done got %b want 00", {dm_req_out, done_out});
    end
    m_data = '0; m_resp = 1'b0; m_misal = 1'b0; m_lo = 2'b00;
    run_access(1'b0, 32'h0000_3008, 32'h0, 2'b10, 1, 1'b0, 32'h0BAD_BEEF, "after_rst");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = {16'h0, 14'($urandom), 2'($urandom_range(0, 3))};
      run_access(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_wait3();
    test_misaligned();
    test_timeout();
    test_bus_error();
    test_reset_in_bus();
    test_back_to_back();
    @(negedge clk);
    mem_req_in = 1'b0;
    #1;
    nvec++;
    if ({dm_req_out, stall_out, done_out} !== 3'b000) begin
      nerr++;
      $display("FAIL final_idle: req/stall/done got %b want 000", {dm_req_out, stall_out, done_out});
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/msrv32_dmem_access_ctrl.md
# msrv32_dmem_access_ctrl

Data-memory access controller for the msrv32 core. It sits between the execute stage and the external data bus, and directly upstream of `msrv32_load_unit`. It accepts one load or store per request, checks alignment, generates the byte-lane write mask and replicated write data, and holds the bus request until the memory returns ready or a timeout fires. It then presents registered read data, the error response and the address low bits to the load unit, and stalls the pipeline for the whole access.

## Interface
- `TIMEOUT_CYCLES`, default 255: wait-state limit before the access aborts with error; range 1..65535.
- `ms_riscv32_mp_clk_in`, input, 1: sole clock, rising edge.
- `ms_riscv32_mp_rst_in`, input, 1: reset, synchronous, active-high.
- `mem_req_in`, input, 1: execute stage requests an access; sampled only in IDLE.
- `mem_wr_in`, input, 1: 1 = store, 0 = load.
- `iadder_in`, input, 32: byte address.
- `rs2_in`, input, 32: store data.
- `load_size_in`, input, 2: 00 byte, 01 half, 10/11 word; applies to loads and stores.
- `dm_req_out`, output, 1: bus request.
- `dm_wr_out`, output, 1: bus write.
- `dm_addr_out`, output, 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dm_wdata_out`, output, 32: lane-replicated store data.
- `dm_wmask_out`, output, 4: byte enables; 0000 on loads.
- `dm_ready_in`, input, 1: memory completes the transfer this cycle.
- `dm_rdata_in`, input, 32: read data, valid when `dm_ready_in` is high.
- `dm_err_in`, input, 1: bus error, valid when `dm_ready_in` is high.
- `stall_out`, output, 1: freeze the pipeline.
- `done_out`, output, 1: one-cycle completion pulse.
- `ms_riscv32_mp_dmdata_out`, output, 32: captured read data, to the load unit.
- `ahb_resp_out`, output, 1: error response, to the load unit.
- `iadder_out_1_to_0_out`, output, 2: latched `addr[1:0]`, to the load unit.
- `misaligned_out`, output, 1: alignment fault, valid with `done_out`.

## Operation
- FSM states: IDLE, BUS, DONE.
- **IDLE**
  - On `mem_req_in`, latch `mem_wr_in`, `iadder_in`, `rs2_in` and `load_size_in`.
  - If the access is misaligned, go to DONE with `misaligned_out`=1 and `ahb_resp_out`=1. No bus cycle is issued.
  - Otherwise go to BUS.
- **Misaligned definition:** half with `addr[0]`=1; word with `addr[1:0]`≠00.
- **BUS**
  - `dm_req_out`=1. Address, write, wdata and mask are stable from the latched values.
  - The timeout counter clears on entry and increments each cycle `dm_ready_in`=0.
  - When `dm_ready_in`=1: capture `dm_rdata_in` (loads only; stores leave the data register unchanged) and `dm_err_in`, then go to DONE.
  - When the counter reaches `TIMEOUT_CYCLES`: set `ahb_resp_out`=1, leave the data register unchanged, and go to DONE.
- **DONE**
  - `done_out`=1 for exactly one cycle, then return to IDLE.
  - A new request is not accepted in DONE.
- **Write mask**
  - Byte: `4'b0001<<addr[1:0]`.
  - Half: 0011 if `addr[1]`=0, else 1100.
  - Word: 1111.
- **Write data**
  - Byte: `{4{rs2[7:0]}}`.
  - Half: `{2{rs2[15:0]}}`.
  - Word: `rs2`.
- **Stall:** `stall_out` = (IDLE & `mem_req_in`) | BUS. It is combinational in IDLE so the requesting instruction is frozen in the same cycle. It is low in DONE so the pipeline advances exactly when the result is available.
- **Hold behaviour:**
  - `ms_riscv32_mp_dmdata_out`, `ahb_resp_out`, `iadder_out_1_to_0_out` and `misaligned_out` hold until the next accepted request.
  - `ahb_resp_out` and `misaligned_out` clear on acceptance.

## Timing
- **Reset:** state IDLE. All outputs are 0, including the data, address and mask registers. The timeout counter is 0.
- **Reset mid-operation:** asserting reset in BUS drops `dm_req_out` on the next edge. No `done_out` is generated. The bus slave must tolerate an abandoned request.
- **Zero-wait load:** accept at edge 0, `dm_req_out` high in cycle 1 with `dm_ready_in`=1, `done_out` in cycle 2. Latency is 2 cycles; N wait states give 2+N.
- **Misaligned access:** latency 1 (IDLE→DONE).
- **Ready and timeout together:** if `dm_ready_in`=1 in the same cycle the counter reaches the limit, ready wins and the response is `dm_err_in`.
- **Counter width:** 16 bits; it saturates and never wraps.

## Structure
- Shared package `msrv32_pkg`: FSM state encoding, the `load_size` encodings (LS_BYTE/LS_HALF/LS_WORD), and the width constant for the timeout counter.
- One sub-module, `msrv32_store_lane_gen`: combinational mask and wdata generation from `size`, `addr[1:0]` and `rs2`.
- The FSM and timeout counter stay in the top module.

## Test plan
- **Store byte:** addr 0x1003, `rs2`=0x000000AB, size 00, ready immediately → `dm_wmask_out`=1000, `dm_wdata_out`=0xABABABAB, `dm_addr_out`=0x1000; `done_out` in cycle 2.
- **Load word with 3 wait states:** `dm_rdata_in`=0x12345678 → `stall_out` high for 5 cycles; then `done_out`, `ms_riscv32_mp_dmdata_out`=0x12345678, `ahb_resp_out`=0.
- **Misaligned half load:** addr 0x2001 → no `dm_req_out`; `done_out` next cycle with `misaligned_out`=1 and `ahb_resp_out`=1.
- **Timeout:** `TIMEOUT_CYCLES`=4, `dm_ready_in` held low → `done_out` in cycle 6, `ahb_resp_out`=1, data register unchanged. A second case asserts ready in the limit cycle → `ahb_resp_out` equals `dm_err_in`.
- **Bus error:** load at addr 0x0002, size 00, `dm_err_in`=1 with ready → `ahb_resp_out`=1, `iadder_out_1_to_0_out`=10.
- **Reset in BUS:** reset asserted during a wait state → next cycle `dm_req_out`=0, `stall_out`=0, all outputs 0, no `done_out`; a following request completes normally.
